hash_target_check: RTL and testbench
====================================

Name: hash_target_check

Overview:
- Downstream stage of the nonce-hashing block; started once the hasher has written NUM_NONCES 32-bit hash words (H0 of each final digest) to memory.
- Streams those words out of the shared memory, compares each against a 32-bit difficulty target and tracks the minimum hash.
- Writes a two-word result record back to memory and presents the same result on ports.
- Consumed by the host/sequencer that decides whether a block was mined.

Parameters:
- NUM_NONCES, 16: hash words to scan; legal range 1..256.
- IDX_W, 8: width of the nonce index fields.

Ports:
- clk  in  1  clock; mem_clk is driven from it.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- hash_addr  in  16  base address of hash word 0.
- result_addr  in  16  base address of the 2-word result record.
- target  in  32  unsigned threshold; a hit is hash < target.
- mem_clk  out  1  equals clk.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_write_data  out  32  memory write data.
- mem_read_data  in  32  memory read data.
- found  out  1  at least one hit in the scanned words.
- hit_idx  out  IDX_W  lowest index that hit; 0 if none.
- min_idx  out  IDX_W  index of the minimum hash.
- min_hash  out  32  minimum hash value.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high) sets state to IDLE and clears mem_we, mem_addr, mem_write_data, found, hit_idx, min_idx and done.
- Reset sets min_hash to 32'hFFFFFFFF.
- Reset asserted mid-scan or mid-write aborts immediately. No further writes are issued.
- Memory timing: an address registered at edge k returns data that is sampled at edge k+2.
- States: IDLE -> SCAN -> DRAIN -> WR0 -> WR1 -> FIN -> IDLE.
- IDLE:
  - On start: latch target, hash_addr and result_addr; set mem_we=0 and mem_addr=hash_addr.
  - Clear found, hit_idx and min_idx; set min_hash=32'hFFFFFFFF.
  - Go to SCAN.
- SCAN: mem_addr increments each cycle until hash_addr+NUM_NONCES-1 has been issued, then go to DRAIN.
- DRAIN: wait until the last word has been sampled.
- Comparison, one word per cycle, starting 2 edges after start is accepted; index i counts 0..NUM_NONCES-1:
  - If word < min_hash (strict): update min_hash and min_idx. Ties keep the lower index.
  - If word < target and found==0: set found=1 and hit_idx=i.
  - target==0 never hits. target==32'hFFFFFFFF hits every word except FFFFFFFF.
- WR0: mem_we=1, mem_addr=result_addr, mem_write_data={found, 23'b0, hit_idx}.
- WR1: mem_we=1, mem_addr=result_addr+1, mem_write_data={min_idx, 24'b0 shifted so min_idx sits in [IDX_W-1:0]} | 0. The 32-bit word is min_idx in [IDX_W-1:0], upper bits 0.
  - The min_hash record word is not written; min_hash is available on the port.
- FIN: mem_we=0, done=1 for exactly one cycle, then IDLE.
- Output hold: found, hit_idx, min_idx and min_hash hold until the next accepted start.
- Latency, start accepted at edge 0:
  - Last word sampled at edge NUM_NONCES+1.
  - WR0 at edge NUM_NONCES+2, WR1 at edge NUM_NONCES+3.
  - done high after edge NUM_NONCES+4 (edge 20 for the default).
- start while not in IDLE is ignored.
- Address arithmetic wraps modulo 2^16.

Optional Feature:
- Macro HASH_TARGET_EARLY_EXIT_EN.
- Defined:
  - At the first hit, stop issuing reads and discard the up to 2 reads still in flight.
  - Go to WR0 on the next cycle.
  - min_hash and min_idx reflect only the words compared so far.
  - Latency for a hit at index i is i+5 edges to done.
- Not defined: the full NUM_NONCES scan always runs and latency is fixed.

Decomposition:
- Package bitcoin_pkg holds:
  - the state enum type;
  - NUM_NONCES_DEFAULT;
  - SHA256 initial H constants, shared with the hasher;
  - the result-record bit positions (FOUND_BIT=31).
- One natural sub-module, hash_min_tracker:
  - Inputs: word, valid, index, target, clear.
  - Outputs: found, hit_idx, min_idx, min_hash.
  - Registered update each valid cycle.
  - Reused by any future multi-nonce search stage.

Test Plan:
- Hashes = 32'h10000000+i (i=0..15), target=32'h00000001 -> found=0, hit_idx=0, min_idx=0, min_hash=32'h10000000; WR0 data 32'h00000000; done after edge 20.
- Hash[5]=32'h00000100, hash[9]=32'h00000050, all others FFFFFFFF, target=32'h00001000 -> found=1, hit_idx=5, min_idx=9, min_hash=32'h00000050; WR0 data 32'h80000005, WR1 data 32'h00000009.
- All hashes equal 32'h20000000, target=32'h20000000 -> found=0 (strict compare), min_idx=0 (tie keeps lowest).
- Reset pulsed at edge 8 of a scan -> mem_we stays 0, no done, outputs at reset values; a new start then completes normally with correct results.
- start re-pulsed during SCAN -> ignored; exactly one WR0/WR1 pair and one done.
- With HASH_TARGET_EARLY_EXIT_EN and a hit at index 3 -> only addresses up to hash_addr+5 issued, WR0 data 32'h80000003, done after edge 8.

Source files
------------

// File: rtl/bitcoin_pkg.sv
// bitcoin_pkg: shared FSM state type, sizing defaults, SHA256 constants and result-record layout.
//   No ports. Imported by the hash_target_check slice and by the upstream hasher.
package bitcoin_pkg;
    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, WR0, WR1, FIN} state_t;
    localparam int NUM_NONCES_DEFAULT = 16;
    localparam logic [31:0] SHA256_H0 = 32'h6a09e667;
    localparam logic [31:0] SHA256_H1 = 32'hbb67ae85;
    localparam logic [31:0] SHA256_H2 = 32'h3c6ef372;
    localparam logic [31:0] SHA256_H3 = 32'ha54ff53a;
    localparam logic [31:0] SHA256_H4 = 32'h510e527f;
    localparam logic [31:0] SHA256_H5 = 32'h9b05688c;
    localparam logic [31:0] SHA256_H6 = 32'h1f83d9ab;
    localparam logic [31:0] SHA256_H7 = 32'h5be0cd19;
    localparam int FOUND_BIT = 31;
endpackage

// File: rtl/hash_target_check_if.sv
// hash_target_check_if: shared-memory bus between the target checker and the hash memory.
//   master: drives mem_clk, mem_we, mem_addr, mem_write_data; samples mem_read_data.
//   slave : the memory side (one-cycle registered read).
interface hash_target_check_if;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    modport master(output mem_clk, mem_we, mem_addr, mem_write_data, input mem_read_data);
    modport slave(input mem_clk, mem_we, mem_addr, mem_write_data, output mem_read_data);
endinterface

// File: rtl/hash_min_tracker.sv
// hash_min_tracker: registered running minimum and first-hit tracker over a stream of hash words.
//   in : clk, reset, clear (restart search), valid, word, index, target
//   out: found, hit_idx (first index with word < target), min_idx, min_hash
module hash_min_tracker #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid,
    input  logic [31:0]      word,
    input  logic [IDX_W-1:0] index,
    input  logic [31:0]      target,
    output logic             found,
    output logic [IDX_W-1:0] hit_idx,
    output logic [IDX_W-1:0] min_idx,
    output logic [31:0]      min_hash
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            found    <= 1'b0;
            hit_idx  <= '0;
            min_idx  <= '0;
            min_hash <= '1;
        end else if (valid) begin
            // strict compare: an equal later word keeps the earlier index
            if (word < min_hash) begin
                min_hash <= word;
                min_idx  <= index;
            end
            if (word < target && !found) begin
                found   <= 1'b1;
                hit_idx <= index;
            end
        end
    end
endmodule

// File: rtl/hash_target_check.sv
// hash_target_check: scans NUM_NONCES hash words from memory, finds the first word below target
// and the minimum word, writes a 2-word result record and pulses done.
//   in : clk, reset (sync, active-high), start, hash_addr, result_addr, target
//   bus: mem (hash_target_check_if.master; mem_clk follows clk, read data returns 2 edges after address)
//   out: found, hit_idx, min_idx, min_hash, done
//   Optional: define HASH_TARGET_EARLY_EXIT_EN to stop scanning at the first hit.
module hash_target_check
    import bitcoin_pkg::*;
#(
    parameter int NUM_NONCES = NUM_NONCES_DEFAULT,
    parameter int IDX_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [15:0]                hash_addr,
    input  logic [15:0]                result_addr,
    input  logic [31:0]                target,
    hash_target_check_if.master        mem,
    output logic                       found,
    output logic [IDX_W-1:0]           hit_idx,
    output logic [IDX_W-1:0]           min_idx,
    output logic [31:0]                min_hash,
    output logic                       done
);
    localparam logic [8:0] LAST = 9'(NUM_NONCES);
    state_t state, state_n;
    logic [8:0] cnt, cnt_n;
    logic [1:0] inflight;
    logic issue, clear, stop, trk_valid, we_n;
    logic [15:0] res_q, addr_n;
    logic [31:0] target_q, wd_n;
    logic [IDX_W-1:0] sidx;

    assign mem.mem_clk = clk;
    assign clear = state == IDLE && start;
`ifdef HASH_TARGET_EARLY_EXIT_EN
    assign stop = found;
`else
    assign stop = 1'b0;
`endif
    // inflight[1] marks the word arriving this cycle; once stopped, late reads are dropped
    assign trk_valid = inflight[1] && !stop;

    hash_min_tracker #(.IDX_W(IDX_W)) u_trk (
        .clk(clk), .reset(reset), .clear(clear), .valid(trk_valid),
        .word(mem.mem_read_data), .index(sidx), .target(target_q),
        .found(found), .hit_idx(hit_idx), .min_idx(min_idx), .min_hash(min_hash)
    );

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        issue = 1'b0;
        addr_n = mem.mem_addr;
        wd_n = mem.mem_write_data;
        case (state)
            IDLE: if (start) begin
                state_n = SCAN;
                cnt_n = 9'd1;
                issue = 1'b1;
                addr_n = hash_addr;
            end
            SCAN: if (stop) state_n = WR0;
                else if (cnt == LAST) state_n = DRAIN;
                else begin
                    cnt_n = cnt + 9'd1;
                    issue = 1'b1;
                    addr_n = mem.mem_addr + 16'd1;
                end
            DRAIN: if (stop || inflight == 2'b00) state_n = WR0;
            WR0: state_n = WR1;
            WR1: state_n = FIN;
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // bus outputs are registered, so they follow the state being entered
        we_n = state_n == WR0 || state_n == WR1;
        if (state_n == WR0) begin
            addr_n = res_q;
            wd_n = 32'(hit_idx);
            wd_n[FOUND_BIT] = found;
        end
        if (state_n == WR1) begin
            addr_n = res_q + 16'd1;
            wd_n = 32'(min_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            inflight <= '0;
            mem.mem_we <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_write_data <= '0;
            done <= 1'b0;
            sidx <= '0;
            target_q <= '0;
            res_q <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            inflight <= state_n == WR0 ? 2'b00 : {inflight[0], issue};
            mem.mem_we <= we_n;
            mem.mem_addr <= addr_n;
            mem.mem_write_data <= wd_n;
            done <= state_n == FIN;
            sidx <= clear ? '0 : sidx + IDX_W'(trk_valid);
            if (clear) begin
                target_q <= target;
                res_q <= result_addr;
            end
        end
    end
endmodule

// File: tb/tb_hash_target_check.sv
// tb_hash_target_check: scoreboard bench for hash_target_check with directed vectors.
module tb_hash_target_check;
    import bitcoin_pkg::*;
`ifdef HASH_TARGET_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        bit          first;
        logic [15:0] rd;
    } wr_t;
    typedef struct {
        logic        f;
        logic [7:0]  hi;
        logic [7:0]  mi;
        logic [31:0] mh;
        int          lat;
    } res_t;

    logic clk, reset, start, found, done;
    logic [15:0] hash_addr, result_addr;
    logic [31:0] target, min_hash, rdata;
    logic [7:0] hit_idx, min_idx;
    logic [31:0] mem [65536];
    logic [15:0] prev_addr;
    wr_t wq[$];
    res_t rq[$];
    wr_t w;
    res_t r;
    time t0;
    int checks, failures;

    hash_target_check_if mif();

    hash_target_check dut (
        .clk(clk), .reset(reset), .start(start), .hash_addr(hash_addr),
        .result_addr(result_addr), .target(target), .mem(mif), .found(found),
        .hit_idx(hit_idx), .min_idx(min_idx), .min_hash(min_hash), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[mif.mem_addr];
    assign mif.mem_read_data = rdata;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    // monitor: pops expectations whenever the DUT writes memory or pulses done
    always @(negedge clk) begin
        if (mif.mem_we) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%h data=%h", mif.mem_addr, mif.mem_write_data);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", 32'(mif.mem_addr), 32'(w.addr));
                chk("wr_data", mif.mem_write_data, w.data);
                if (w.first) chk("last_read_addr", 32'(prev_addr), 32'(w.rd));
            end
        end else prev_addr = mif.mem_addr;
        if (done) begin
            if (rq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                r = rq.pop_front();
                chk("found", 32'(found), 32'(r.f));
                chk("hit_idx", 32'(hit_idx), 32'(r.hi));
                chk("min_idx", 32'(min_idx), 32'(r.mi));
                chk("min_hash", min_hash, r.mh);
                chk("latency", 32'(int'(($time - t0 - 5) / 10)), 32'(r.lat));
            end
        end
    end

    task automatic fill(input logic [15:0] ba, input logic [31:0] v);
        for (int i = 0; i < 16; i++) mem[ba + 16'(i)] = v;
    endtask

    task automatic run(input logic [15:0] ba, input logic [15:0] ra, input logic [31:0] tg,
                       input logic f, input logic [7:0] hi, input logic [7:0] mi,
                       input logic [31:0] mh, input int lat, input logic [15:0] last_rd,
                       input bit repulse);
        wq.push_back('{ra, {f, 23'd0, hi}, 1'b1, last_rd});
        wq.push_back('{ra + 16'd1, {24'd0, mi}, 1'b0, 16'd0});
        rq.push_back('{f, hi, mi, mh, lat});
        @(negedge clk);
        hash_addr = ba;
        result_addr = ra;
        target = tg;
        start = 1'b1;
        @(posedge clk);
        t0 = $time;
        @(negedge clk);
        start = 1'b0;
        target = ~tg;
        for (int k = 1; k < 60 && rq.size() != 0; k++) begin
            start = repulse && (k == 3 || k == 7);
            @(negedge clk);
        end
        start = 1'b0;
        if (rq.size() != 0 || wq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout pending_results=%0d pending_writes=%0d expected=0", rq.size(), wq.size());
            rq.delete();
            wq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        start = 1'b0;
        hash_addr = '0;
        result_addr = '0;
        target = '0;
        prev_addr = '0;
        t0 = 0;
        for (int i = 0; i < 16; i++) mem[16'h0100 + 16'(i)] = 32'h10000000 + 32'(i);
        fill(16'h0200, 32'hFFFFFFFF);
        mem[16'h0205] = 32'h00000100;
        mem[16'h0209] = 32'h00000050;
        fill(16'h0400, 32'h20000000);
        fill(16'hFFF8, 32'h20000000);
        fill(16'h0300, 32'hFFFFFFF0);
        mem[16'h0303] = 32'h00000005;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_found", 32'(found), 32'd0);
        chk("rst_hit_idx", 32'(hit_idx), 32'd0);
        chk("rst_min_idx", 32'(min_idx), 32'd0);
        chk("rst_min_hash", min_hash, 32'hFFFFFFFF);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_we", 32'(mif.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mif.mem_addr), 32'd0);
        // no word below 1
        run(16'h0100, 16'h1000, 32'h00000001, 1'b0, 8'd0, 8'd0, 32'h10000000, 20, 16'h010F, 1'b0);
        // first hit at 5, minimum at 9 (early exit sees words 0..5 only)
        run(16'h0200, 16'h1010, 32'h00001000, 1'b1, 8'd5, EE ? 8'd5 : 8'd9,
            EE ? 32'h00000100 : 32'h00000050, EE ? 10 : 20, EE ? 16'h0207 : 16'h020F, 1'b0);
        // equal to target is not a hit; ties keep index 0
        run(16'h0400, 16'h1020, 32'h20000000, 1'b0, 8'd0, 8'd0, 32'h20000000, 20, 16'h040F, 1'b0);
        // reset at edge 8 of a scan aborts it
        @(negedge clk);
        hash_addr = 16'h0100;
        result_addr = 16'h1030;
        target = 32'hFFFFFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_found", 32'(found), 32'd0);
        chk("abort_hit_idx", 32'(hit_idx), 32'd0);
        chk("abort_min_idx", 32'(min_idx), 32'd0);
        chk("abort_min_hash", min_hash, 32'hFFFFFFFF);
        chk("abort_mem_we", 32'(mif.mem_we), 32'd0);
        // fresh start after abort; all-ones target hits word 0
        run(16'h0100, 16'h1030, 32'hFFFFFFFF, 1'b1, 8'd0, 8'd0, 32'h10000000,
            EE ? 5 : 20, EE ? 16'h0102 : 16'h010F, 1'b0);
        // wrapping addresses, target 0, start re-pulsed mid-scan
        run(16'hFFF8, 16'hFFFF, 32'h00000000, 1'b0, 8'd0, 8'd0, 32'h20000000, 20, 16'h0007, 1'b1);
        // hit at index 3
        run(16'h0300, 16'h1040, 32'h00000100, 1'b1, 8'd3, 8'd3, 32'h00000005,
            EE ? 8 : 20, EE ? 16'h0305 : 16'h030F, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
